// File: rtl/pdm_capture_ctrl_if.sv
// Bus bundle between the PDM capture controller, its command source,
// the PDM datapath and the capture buffer.
interface pdm_capture_ctrl_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_cnt;
  logic              wrap_en;
  logic              pdm_bsy;
  logic              pdm_wvalid;
  logic [DATA_W-1:0] pdm_dout;
  logic [1:0]        ctrl;
  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              err;
  logic              ovf;

  modport master (
    output start, stop, base_addr, word_cnt, wrap_en, pdm_bsy, pdm_wvalid, pdm_dout,
    input  ctrl, addr, wr_en, wr_data, busy, done, err, ovf
  );

  modport slave (
    input  start, stop, base_addr, word_cnt, wrap_en, pdm_bsy, pdm_wvalid, pdm_dout,
    output ctrl, addr, wr_en, wr_data, busy, done, err, ovf
  );
endinterface

// File: rtl/pdm_capture_ctrl.sv
// Sequences a PDM capture (clear, start, wait busy, stream words into a
// linear or circular buffer) and reports completion, arm timeout and drops.
module pdm_capture_ctrl #(
  parameter int unsigned ADDR_STEP   = 4,
  parameter int unsigned BSY_TIMEOUT = 255
) (
  input  logic              AHBclk,
  input  logic              rst,
  pdm_capture_ctrl_if.slave bus
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned TMO_W  = (BSY_TIMEOUT > 1) ? $clog2(BSY_TIMEOUT) : 1;

  localparam logic [1:0] CTRL_IDLE  = 2'b00;
  localparam logic [1:0] CTRL_CLEAR = 2'b10;
  localparam logic [1:0] CTRL_START = 2'b01;

  typedef enum logic [2:0] {
    IDLE, CLEAR, ARM, WAIT_BSY, RUN, HALT, FIN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic              wrap_q, wrap_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;

  // Next-state and next-output logic; ctrl/busy/done are decoded from the
  // next state so the registered outputs line up with the state they belong to.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    wrap_d    = wrap_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    ovf_d     = ovf_q;

    if (bus.pdm_wvalid && (state_q != RUN)) ovf_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (bus.start && (bus.word_cnt != '0)) begin
          state_d = CLEAR;
          base_d  = bus.base_addr;
          len_d   = bus.word_cnt;
          wrap_d  = bus.wrap_en;
          ptr_d   = bus.base_addr;
          cnt_d   = '0;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      CLEAR: state_d = bus.stop ? HALT : ARM;
      ARM: begin
        state_d = bus.stop ? HALT : WAIT_BSY;
        tmo_d   = '0;
      end
      WAIT_BSY: begin
        if (bus.stop) begin
          state_d = HALT;
        end else if (bus.pdm_bsy) begin
          state_d = RUN;
        end else if (tmo_q == TMO_W'(BSY_TIMEOUT - 1)) begin
          state_d = FIN;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RUN: begin
        if (bus.pdm_wvalid) begin
          wr_en_d   = 1'b1;
          wr_data_d = bus.pdm_dout;
          addr_d    = ptr_q;
          ptr_d     = ptr_q + ADDR_W'(ADDR_STEP);
          cnt_d     = cnt_q + CNT_W'(1);
          // Terminal word: circular buffers rewind, linear ones finish.
          if ((cnt_q + CNT_W'(1)) == len_q) begin
            if (wrap_q) begin
              ptr_d = base_q;
              cnt_d = '0;
            end else begin
              state_d = HALT;
            end
          end
        end
        if (bus.stop) state_d = HALT;
      end
      HALT:    state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ctrl_d = CTRL_IDLE;
    if ((state_d == CLEAR) || (state_d == HALT)) begin
      ctrl_d = CTRL_CLEAR;
    end else if (state_d == ARM) begin
      ctrl_d = CTRL_START;
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge AHBclk) begin
    if (!rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      wrap_q    <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      ctrl_q    <= CTRL_IDLE;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      wrap_q    <= wrap_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      ctrl_q    <= ctrl_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.ctrl    = ctrl_q;
  assign bus.addr    = addr_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// Randomized bench for pdm_capture_ctrl: each capture predicts its buffer
// writes and flags from address arithmetic and compares with what was seen.
module tb_pdm_capture_ctrl;
  localparam int unsigned STEP = 4;
  localparam int unsigned TMO  = 255;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pdm_capture_ctrl_if bus();

  pdm_capture_ctrl #(.ADDR_STEP(STEP), .BSY_TIMEOUT(TMO)) dut (
    .AHBclk(clk),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Passive monitor: buffer writes, done pulses, ctrl in the cycle before done.
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int          done_cnt = 0;
  logic [1:0]  prev_ctrl = 2'b00;
  logic [1:0]  ctrl_before_done = 2'b11;

  always @(negedge clk) begin
    if (bus.wr_en) begin
      obs_addr.push_back(bus.addr);
      obs_data.push_back(bus.wr_data);
    end
    if (bus.done) begin
      done_cnt++;
      ctrl_before_done = prev_ctrl;
    end
    prev_ctrl = bus.ctrl;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, ":ctrl"},    32'(bus.ctrl),    32'd0);
    check({nm, ":addr"},    bus.addr,         32'd0);
    check({nm, ":wr_en"},   32'(bus.wr_en),   32'd0);
    check({nm, ":wr_data"}, bus.wr_data,      32'd0);
    check({nm, ":busy"},    32'(bus.busy),    32'd0);
    check({nm, ":done"},    32'(bus.done),    32'd0);
    check({nm, ":err"},     32'(bus.err),     32'd0);
    check({nm, ":ovf"},     32'(bus.ovf),     32'd0);
  endtask

  // One complete capture. stop_mode: 0 none, 1 with last word, 2 one cycle after.
  task automatic run_cap(input string nm, input logic [31:0] base, input logic [15:0] len,
                         input bit wrap, input int bsy_dly, input int nwords,
                         input int stop_mode, input bit extra, input bit poke);
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    logic [31:0] data;
    int          o0, d0, n, nobs;
    bit          exp_ovf;

    o0 = obs_addr.size();
    d0 = done_cnt;
    bus.base_addr = base;
    bus.word_cnt  = len;
    bus.wrap_en   = wrap;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.base_addr = $urandom;
    bus.word_cnt  = 16'($urandom);
    check({nm, ":clear_ctrl"}, 32'(bus.ctrl), 32'h2);
    check({nm, ":clear_busy"}, 32'(bus.busy), 32'd1);
    check({nm, ":clear_err"},  32'(bus.err),  32'd0);
    check({nm, ":clear_ovf"},  32'(bus.ovf),  32'd0);
    tick();
    check({nm, ":arm_ctrl"}, 32'(bus.ctrl), 32'h1);
    tick();
    check({nm, ":wait_ctrl"}, 32'(bus.ctrl), 32'h0);
    repeat (bsy_dly) tick();
    bus.pdm_bsy = 1'b1;
    tick();
    check({nm, ":run_busy"}, 32'(bus.busy), 32'd1);
    if (poke) begin
      bus.start    = 1'b1;
      bus.word_cnt = 16'd1;
      bus.wrap_en  = ~wrap;
      tick();
      bus.start    = 1'b0;
    end
    for (int k = 0; k < nwords; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      data = $urandom;
      bus.pdm_wvalid = 1'b1;
      bus.pdm_dout   = data;
      if ((stop_mode == 1) && (k == nwords - 1)) bus.stop = 1'b1;
      tick();
      bus.pdm_wvalid = 1'b0;
      bus.stop       = 1'b0;
      if (wrap || (k < int'(len))) begin
        exp_a.push_back(base + 32'(STEP * (k % int'(len))));
        exp_d.push_back(data);
      end
    end
    if (stop_mode == 2) begin
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
    end
    if (extra) begin
      bus.pdm_wvalid = 1'b1;
      bus.pdm_dout   = $urandom;
      tick();
      bus.pdm_wvalid = 1'b0;
    end
    bus.pdm_bsy = 1'b0;
    n = 0;
    while (bus.busy && (n < 50)) begin
      tick();
      n++;
    end
    tick();
    exp_ovf = extra || (!wrap && (nwords > int'(len)));
    check({nm, ":idle_busy"}, 32'(bus.busy), 32'd0);
    check({nm, ":done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({nm, ":halt_ctrl"}, 32'(ctrl_before_done), 32'h2);
    check({nm, ":err"}, 32'(bus.err), 32'd0);
    check({nm, ":ovf"}, 32'(bus.ovf), 32'(exp_ovf));
    nobs = obs_addr.size() - o0;
    check({nm, ":nwrites"}, 32'(nobs), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < nobs; i++) begin
      check($sformatf("%s:addr%0d", nm, i), obs_addr[o0 + i], exp_a[i]);
      check($sformatf("%s:data%0d", nm, i), obs_data[o0 + i], exp_d[i]);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int          n, o0, d0, len, nw, sm;
    bit          wrap;
    logic [31:0] base;

    rst = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.base_addr = '0; bus.word_cnt = '0;
    bus.wrap_en = 1'b0; bus.pdm_bsy = 1'b0; bus.pdm_wvalid = 1'b0; bus.pdm_dout = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    run_cap("lin3",  32'h4000_0000, 16'd3, 1'b0, 1, 3, 0, 1'b0, 1'b0);
    run_cap("wrap2", 32'h4000_0000, 16'd2, 1'b1, 0, 5, 2, 1'b0, 1'b0);
    run_cap("stop2", 32'h4000_0000, 16'd8, 1'b0, 2, 2, 1, 1'b1, 1'b0);

    // Arm timeout: pdm_bsy never rises.
    o0 = obs_addr.size();
    d0 = done_cnt;
    bus.base_addr = 32'h2000_0000; bus.word_cnt = 16'd4; bus.wrap_en = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    n = 0;
    while (!bus.done && (n < 400)) begin
      tick();
      n++;
    end
    check("tmo:cycles", 32'(n), 32'(TMO));
    check("tmo:err", 32'(bus.err), 32'd1);
    tick();
    check("tmo:done_pulses", 32'(done_cnt - d0), 32'd1);
    check("tmo:ctrl_before_done", 32'(ctrl_before_done), 32'h0);
    check("tmo:nwrites", 32'(obs_addr.size() - o0), 32'd0);
    check("tmo:busy", 32'(bus.busy), 32'd0);

    // Zero-length start is ignored and leaves the sticky err alone.
    bus.word_cnt = 16'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("zero:busy", 32'(bus.busy), 32'd0);
    check("zero:ctrl", 32'(bus.ctrl), 32'h0);
    check("zero:err",  32'(bus.err),  32'd1);

    run_cap("poke", 32'h0000_1000, 16'd4, 1'b0, 0, 4, 0, 1'b0, 1'b1);

    for (int it = 0; it < 40; it++) begin
      base = $urandom & 32'hFFFF_FFFC;
      len  = $urandom_range(1, 5);
      wrap = 1'($urandom);
      nw   = wrap ? $urandom_range(1, 12) : $urandom_range(1, len + 2);
      sm   = wrap ? $urandom_range(1, 2) : $urandom_range(0, 2);
      if (!wrap && (nw < len) && (sm == 0)) sm = 2;
      run_cap($sformatf("rnd%0d", it), base, 16'(len), wrap, $urandom_range(0, 4), nw, sm,
              1'($urandom), 1'($urandom));
    end

    // Reset mid-capture: the write already issued stays, nothing after it.
    o0 = obs_addr.size();
    d0 = done_cnt;
    bus.base_addr = 32'h0000_8000; bus.word_cnt = 16'd8; bus.wrap_en = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.pdm_bsy = 1'b1;
    tick();
    bus.pdm_wvalid = 1'b1;
    bus.pdm_dout   = 32'hA5A5_0001;
    tick();
    check("rstrun:wr_en", 32'(bus.wr_en), 32'd1);
    check("rstrun:addr", bus.addr, 32'h0000_8000);
    rst = 1'b0;
    bus.pdm_dout = 32'hA5A5_0002;
    tick();
    check_reset_outputs("rstrun");
    rst = 1'b1;
    bus.pdm_wvalid = 1'b0;
    bus.pdm_bsy = 1'b0;
    repeat (5) tick();
    check("rstrun:done_pulses", 32'(done_cnt - d0), 32'd0);
    check("rstrun:nwrites", 32'(obs_addr.size() - o0), 32'd1);
    check("rstrun:idle_busy", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pdm_capture_ctrl.md
PDM_CAPTURE_CTRL -- requirements
Module: pdm_capture_ctrl

Interface
REQ-001 Parameter ADDR_STEP, default 4, byte increment of addr per captured word.
REQ-002 Parameter BSY_TIMEOUT, default 255, maximum AHBclk cycles from arm until pdm_bsy=1.
REQ-003 AHBclk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  one-cycle capture request.
REQ-006 stop  in  1  one-cycle abort request.
REQ-007 base_addr  in  32  first write address, sampled on accepted start.
REQ-008 word_cnt  in  16  words per capture, sampled on accepted start.
REQ-009 wrap_en  in  1  1 = circular buffer; sampled on accepted start.
REQ-010 pdm_bsy  in  1  busy flag from PDM datapath.
REQ-011 pdm_wvalid  in  1  one-cycle strobe per completed 32-bit PDM word.
REQ-012 pdm_dout  in  32  PDM word, valid with pdm_wvalid.
REQ-013 ctrl  out  2  command to PDM datapath: 00 idle, 10 clear, 01 start.
REQ-014 addr  out  32  buffer write address.
REQ-015 wr_en  out  1  one-cycle buffer write strobe.
REQ-016 wr_data  out  32  buffer write data.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle completion pulse.
REQ-019 err  out  1  sticky arm-timeout flag.
REQ-020 ovf  out  1  sticky word-dropped flag.

Function
REQ-021 FSM states SHALL be IDLE, CLEAR, ARM, WAIT_BSY, RUN, HALT, FIN.
REQ-022 IDLE: start=1 with word_cnt!=0 -> CLEAR, capture base_addr/word_cnt/wrap_en, clear err and ovf, zero word counter; start with word_cnt=0 ignored, no flag change.
REQ-023 CLEAR: ctrl=10 for exactly one cycle -> ARM.
REQ-024 ARM: ctrl=01 for exactly one cycle -> WAIT_BSY, timeout counter cleared.
REQ-025 WAIT_BSY: ctrl=00; pdm_bsy=1 -> RUN; counter reaching BSY_TIMEOUT without pdm_bsy -> FIN with err=1.
REQ-026 RUN: each pdm_wvalid -> next cycle wr_en=1, wr_data=pdm_dout, addr=current pointer (1-cycle latency); pointer += ADDR_STEP, counter +1, modulo 2^32.
REQ-027 RUN, wrap_en=0: write of word word_cnt -> HALT in same cycle as that wr_en.
REQ-028 RUN, wrap_en=1: after word word_cnt, pointer reloads base_addr, counter reloads 0, stays in RUN until stop.
REQ-029 stop in RUN, WAIT_BSY, CLEAR or ARM -> HALT; stop in IDLE, HALT or FIN ignored.
REQ-030 stop coincident with pdm_wvalid in RUN: that word is still written; then HALT.
REQ-031 HALT: ctrl=10 one cycle (datapath cleared) -> FIN.
REQ-032 FIN: done=1 one cycle -> IDLE.
REQ-033 pdm_wvalid outside RUN (or the cycle RUN is exited by terminal count) SHALL set ovf, no write.
REQ-034 start while busy=1 SHALL be ignored.
REQ-035 ctrl SHALL be 00 in all states/cycles not listed in REQ-023/024/031.

Reset
REQ-036 rst=0 at an edge SHALL force IDLE, ctrl=00, addr=0, wr_en=0, wr_data=0, busy=0, done=0, err=0, ovf=0, counters 0.
REQ-037 rst mid-capture SHALL abort without done pulse and without a pending write.

Verification
REQ-038 base=0x40000000, cnt=3, wrap=0, bsy rises 2 cycles after ARM, 3 wvalid -> ctrl 10,01,00...; writes to 0x40000000/04/08; HALT ctrl=10; done one pulse; busy low after.
REQ-039 base=0x40000000, cnt=2, wrap=1, 5 wvalid then stop -> addrs 0x..00,04,00,04,00; done after HALT; ovf=0.
REQ-040 pdm_bsy held 0 after ARM -> FIN after 255 cycles, err=1, done pulse, no writes; next start clears err.
REQ-041 stop same cycle as 2nd wvalid, cnt=8 -> 2 writes, HALT, done; wvalid one cycle after stop -> ovf=1.
REQ-042 start with word_cnt=0, and start during RUN -> both ignored, state and outputs unchanged.
REQ-043 rst=0 in RUN one cycle after wvalid -> no wr_en, all outputs at reset values next cycle, no done.
